// File: rtl/key_pkg.sv
// key_pkg: shared constants and types for the key event encoder.
// Holds the default key count, the matching key-code type, and default
// auto-repeat timing used when the block is built with KEY_REPEAT_EN.
package key_pkg;

  localparam int N_KEYS_DEF        = 16;
  localparam int KEY_IDX_W         = $clog2(N_KEYS_DEF);
  localparam int FIFO_DEPTH_DEF    = 4;
  localparam int REPEAT_DELAY_DEF  = 25_000_000;
  localparam int REPEAT_PERIOD_DEF = 5_000_000;

  typedef logic [KEY_IDX_W-1:0] key_code_t;

endpackage

// File: rtl/key_fifo.sv
// key_fifo: small first-word fall-through FIFO for key events.
// The head entry is presented combinationally on o_data whenever the FIFO
// is non-empty, and reads as zero when it is empty. A push together with a
// pop on a full FIFO is accepted and leaves the count unchanged; a pop on
// an empty FIFO is ignored. DEPTH must be a power of two so the pointers
// wrap naturally.
module key_fifo
  import key_pkg::*;
#(
  parameter int WIDTH = KEY_IDX_W,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

  // Storage write: data array needs no reset, emptiness is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping with synchronous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// key_event_encoder: turns debounced key presses into key-code events.
// Each 0->1 transition on btn marks the key pending; the lowest pending key
// is pushed into a FWFT FIFO whenever there is room (or a pop frees a slot),
// so simultaneous presses are serialised lowest index first without loss.
// A second press of a key whose earlier press is still pending is dropped
// and raises the sticky overflow flag.
// Optional feature macro: KEY_REPEAT_EN enables auto-repeat of the most
// recently pressed key while it stays held.
module key_event_encoder
  import key_pkg::*;
#(
  parameter int N_KEYS        = N_KEYS_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_KEYS-1:0]         btn,
  output logic                      key_valid,
  input  logic                      key_ready,
  output logic [$clog2(N_KEYS)-1:0] key_code,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int                KW      = $clog2(N_KEYS);
  localparam logic [N_KEYS-1:0] ONE_LSB = {{(N_KEYS-1){1'b0}}, 1'b1};

  logic [N_KEYS-1:0] r_btn_q;
  logic [N_KEYS-1:0] r_pending;
  logic              r_overflow;
  logic [N_KEYS-1:0] w_rise;
  logic [N_KEYS-1:0] w_lowest;
  logic [N_KEYS-1:0] w_grant;
  logic [N_KEYS-1:0] w_rep_set;
  logic [N_KEYS-1:0] w_ovf_hit;
  logic [KW-1:0]     w_grant_code;
  logic              w_pop;
  logic              w_push;
  logic              w_push_ok;
  logic              w_full;
  logic              w_empty;

  assign w_rise    = btn & ~r_btn_q;
  assign key_valid = ~w_empty;
  assign w_pop     = key_valid & key_ready;
  assign w_push_ok = ~w_full | w_pop;
  // Two's-complement trick isolates the lowest set pending bit.
  assign w_lowest  = r_pending & (~r_pending + ONE_LSB);
  assign w_grant   = w_push_ok ? w_lowest : {N_KEYS{1'b0}};
  assign w_push    = |w_grant;
  // A press that lands on a still-pending, not-just-granted key is lost.
  assign w_ovf_hit = w_rise & r_pending & ~w_grant;
  assign overflow  = r_overflow;

  // Encode the one-hot grant into the key index pushed into the FIFO.
  always_comb begin
    w_grant_code = {KW{1'b0}};
    for (int i = 0; i < N_KEYS; i++) begin
      w_grant_code = w_grant_code | (w_grant[i] ? KW'(i) : {KW{1'b0}});
    end
  end

  // Previous key levels for edge detection; loading during reset suppresses held keys.
  always_ff @(posedge clk) begin
    r_btn_q <= btn;
  end

  // Pending set: retire the granted key, add new presses and repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= {N_KEYS{1'b0}};
    end else begin
      r_pending <= (r_pending & ~w_grant) | w_rise | w_rep_set;
    end
  end

  // Sticky overflow flag; a new loss in the same cycle wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (|w_ovf_hit) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  logic [N_KEYS-1:0] r_from_rise;
  logic [KW-1:0]     r_rep_key;
  logic [RW-1:0]     r_rep_cnt;
  logic              w_rise_grant;
  logic              w_rep_held;
  logic              w_rep_fire;

  // Only grants that originate from a real press retarget the repeat timer.
  assign w_rise_grant = |(w_grant & r_from_rise);
  assign w_rep_held   = btn[r_rep_key];
  assign w_rep_fire   = ~w_rise_grant & w_rep_held &
                        (r_rep_cnt == RW'(REPEAT_DELAY - 1));
  assign w_rep_set    = w_rep_fire ? (ONE_LSB << r_rep_key) : {N_KEYS{1'b0}};

  // Repeat tracking: key of the last press grant and its hold timer.
  // The timer restarts at 1 on the grant because the key was already held
  // for the cycle in which the press was sampled, so the first repeat lands
  // REPEAT_DELAY cycles after the press event itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_from_rise <= {N_KEYS{1'b0}};
      r_rep_key   <= {KW{1'b0}};
      r_rep_cnt   <= {RW{1'b0}};
    end else begin
      r_from_rise <= (r_from_rise & ~w_grant) | w_rise;
      if (w_rise_grant) begin
        r_rep_key <= w_grant_code;
        r_rep_cnt <= {{(RW-1){1'b0}}, 1'b1};
      end else if (!w_rep_held) begin
        r_rep_cnt <= {RW{1'b0}};
      end else if (w_rep_fire) begin
        r_rep_cnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end
    end
  end
`else
  localparam int unused_rep_cfg = REPEAT_DELAY + REPEAT_PERIOD;

  assign w_rep_set = {N_KEYS{1'b0}};
`endif

  key_fifo #(
    .WIDTH (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_grant_code),
    .i_pop   (w_pop),
    .o_data  (key_code),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed testbench for key_event_encoder (N_KEYS=16, FIFO_DEPTH=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=5). Inputs change and outputs are sampled
// on the falling clock edge.
module tb_key_event_encoder;
  import key_pkg::*;

`ifdef KEY_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] btn;
  logic        key_valid;
  logic        key_ready;
  key_code_t   key_code;
  logic        overflow;
  logic        ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_event_encoder #(
    .N_KEYS        (16),
    .FIFO_DEPTH    (4),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 16'h0008; key_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    n_tests++;
    if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", key_code); end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (key_valid !== 1'b0) begin n_fail++; $display("FAIL held_through_reset cyc %0d: valid %b want 0", i, key_valid); end
    end
    btn = 16'h0000;
    repeat (2) tick();
  endtask

  task automatic test_single_press();
    int n_ev;
    key_ready = 1'b1;
    btn = 16'h0020;
    tick();
    n_tests++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency1: valid %b want 0", key_valid); end
    tick();
    n_tests++;
    if (key_valid !== 1'b1 || key_code !== 4'd5) begin
      n_fail++; $display("FAIL single_event: valid %b code %0d want 1/5", key_valid, key_code);
    end
    n_ev = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (key_valid === 1'b1) n_ev++;
    end
    n_tests++;
    if (n_ev !== 0) begin n_fail++; $display("FAIL single_only_once: extra events %0d want 0", n_ev); end
    btn = 16'h0000;
    n_ev = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (key_valid === 1'b1) n_ev++;
    end
    n_tests++;
    if (n_ev !== 0) begin n_fail++; $display("FAIL release_no_event: events %0d want 0", n_ev); end
  endtask

  task automatic test_simultaneous();
    int exp_codes [3] = '{2, 9, 12};
    key_ready = 1'b1;
    btn = 16'h1204;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (key_valid !== 1'b1 || key_code !== key_code_t'(exp_codes[i])) begin
        n_fail++; $display("FAIL simul_order[%0d]: valid %b code %0d want 1/%0d", i, key_valid, key_code, exp_codes[i]);
      end
      tick();
    end
    n_tests++;
    if (key_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL simul_end: valid %b ovf %b want 0/0", key_valid, overflow);
    end
    btn = 16'h0000;
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    key_ready = 1'b0;
    btn = 16'h003F;
    repeat (8) tick();
    n_tests++;
    if (key_valid !== 1'b1 || key_code !== 4'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_hold: valid %b code %0d ovf %b want 1/0/0", key_valid, key_code, overflow);
    end
    btn = 16'h0000;
    tick();
    key_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (key_valid !== 1'b1 || key_code !== key_code_t'(i)) begin
        n_fail++; $display("FAIL drain_order[%0d]: valid %b code %0d want 1/%0d", i, key_valid, key_code, i);
      end
      tick();
    end
    n_tests++;
    if (key_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL drain_end: valid %b ovf %b want 0/0", key_valid, overflow);
    end
  endtask

  task automatic test_overflow();
    int exp_codes [5] = '{0, 1, 2, 3, 7};
    int n_ev;
    key_ready = 1'b0;
    btn = 16'h000F;
    repeat (6) tick();
    btn = 16'h0000;
    tick();
    btn = 16'h0080;
    tick();
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_first_press: got %b want 0", overflow); end
    btn = 16'h0000;
    tick();
    btn = 16'h0080;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_tests++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    btn = 16'h0000;
    tick();
    key_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (key_valid !== 1'b1 || key_code !== key_code_t'(exp_codes[i])) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: valid %b code %0d want 1/%0d", i, key_valid, key_code, exp_codes[i]);
      end
      tick();
    end
    n_ev = 0;
    for (int i = 0; i < 4; i++) begin
      if (key_valid === 1'b1) n_ev++;
      tick();
    end
    n_tests++;
    if (n_ev !== 0) begin n_fail++; $display("FAIL ovf_single_7: extra events %0d want 0", n_ev); end
    n_tests++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_reset_flush();
    int n_ev;
    key_ready = 1'b0;
    btn = 16'h0050;
    repeat (2) tick();
    n_tests++;
    if (key_valid !== 1'b1 || key_code !== 4'd4) begin
      n_fail++; $display("FAIL flush_pre: valid %b code %0d want 1/4", key_valid, key_code);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (key_valid !== 1'b0 || key_code !== 4'd0) begin
      n_fail++; $display("FAIL flush_now: valid %b code %0d want 0/0", key_valid, key_code);
    end
    n_ev = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (key_valid === 1'b1) n_ev++;
    end
    n_tests++;
    if (n_ev !== 0) begin n_fail++; $display("FAIL flush_pending: events %0d want 0", n_ev); end
    btn = 16'h0000;
    repeat (2) tick();
  endtask

  task automatic test_hold_repeat();
    logic exp_v;
    key_ready = 1'b1;
    btn = 16'h0002;
    for (int t = 0; t <= 60; t++) begin
      tick();
      exp_v = (t == 1) || (REP_ON && (t == 21 || t == 26 || t == 31 || t == 36));
      n_tests++;
      if (key_valid !== exp_v) begin
        n_fail++; $display("FAIL hold_valid t=%0d: got %b want %b", t, key_valid, exp_v);
      end
      if (exp_v) begin
        n_tests++;
        if (key_code !== 4'd1) begin n_fail++; $display("FAIL hold_code t=%0d: got %0d want 1", t, key_code); end
      end
      if (t == 39) btn = 16'h0000;
    end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL hold_ovf: got %b want 0", overflow); end
  endtask

  initial begin
    rst = 1'b1; btn = 16'h0008; key_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_single_press();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_reset_flush();
    test_hold_repeat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
